ftoi: RTL and testbench
=======================

# ftoi

Single-precision IEEE-754 to signed 32-bit integer converter for the FPU. It takes a float32 operand and produces its two's-complement int32 value, rounded to nearest with ties away from zero, saturated on overflow. It is a fully pipelined, single-stage registered unit that accepts a new operand every cycle.

## Interface

Parameters: none.

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  reset; asynchronous, active-low
- x  input  32  float32 operand: sign [31], exponent [30:23], mantissa [22:0]
- y  output  32  signed int32 result, registered

## Operation

Fields:
- s = x[31], e = x[30:23], m = x[22:0].
- Significand is {1, m} (24 bits) when e != 0.

Zero and small values:
- e == 0 (zero or denormal) -> 0.
- e <= 125 (|x| < 0.5) -> 0.
- e == 126 (0.5 <= |x| < 1) -> magnitude 1. This is the tie/round-up case.

Normal range, 127 <= e <= 157:
- Integer part = significand shifted by (e - 150): right shift when e < 150, left shift when e >= 150.
- For right shifts, the round bit is the first bit shifted out. Add 1 to the magnitude when the round bit is 1. This gives ties away from zero; sticky bits do not matter.
- Form the result as the magnitude for s = 0, or its two's complement for s = 1.

Overflow and saturation:
- e >= 158 (|x| >= 2^31), including ±Inf -> 0x7FFFFFFF if s = 0, 0x80000000 if s = 1.
- NaN (e == 255, m != 0) -> 0x7FFFFFFF.
- e == 157 with rounding: the magnitude cannot exceed 2^31 - 1 except for exactly -2^31, which is returned as 0x80000000.
- The magnitude path is 32 bits wide plus a carry bit for rounding. Any magnitude > 0x7FFFFFFF for positive input saturates to 0x7FFFFFFF.

Negative zero:
- -0.0 -> 0.

## Timing

- y is registered; latency is 1 cycle. The value of x sampled at rising edge N appears on y immediately after edge N.
- Throughput is one conversion per cycle, with no handshake and no stall.
- While rstn = 0, y = 0x00000000, applied asynchronously.
- Release of rstn takes effect at the next rising edge; the first conversion captures x at that edge.
- If reset is asserted mid-stream, the in-flight result is discarded.
- An X/undriven x before the first valid operand may propagate to y. The bench does not check y until 1 cycle after a defined x.

## Structure

Shared package `fpu_pkg` holds:
- Constants: FLOAT_BIAS = 127, EXP_W = 8, MANT_W = 23, INT_MAX = 32'h7FFFFFFF, INT_MIN = 32'h80000000.
- Typedef float32_t: packed struct {sign, exp, mant}.

Sub-modules:
- `ftoi_shift` (combinational) is the natural split. It takes the 24-bit significand and the exponent, and returns the 32-bit truncated magnitude, the round bit and an overflow flag.
- The top level handles special cases, rounding, negation, saturation and the output register.

## Test plan

- Basic conversion: x = 0x40400000 (3.0) -> y = 3 one cycle later; then x = 0x00000000 -> 0; then x = 0x80000000 (-0.0) -> 0.
- Rounding: 0xC048F5C3 (-3.14) -> 0xFFFFFFFD (-3); 0x40200000 (2.5) -> 3; 0x3C23D70A (0.01) -> 0; 0x3F000000 (0.5) -> 1; 0xBFC00000 (-1.5) -> 0xFFFFFFFE (-2).
- Large values: 0x4E6E6B28 (1.0e9) -> 0x3B9ACA00; 0x4EFFFFFF -> 0x7FFFFF80.
- Saturation: 0x4F000000 (2^31) -> 0x7FFFFFFF; 0xCF000000 (-2^31) -> 0x80000000; 0x7F800000 (+Inf) -> 0x7FFFFFFF; 0xFF800000 (-Inf) -> 0x80000000; 0x7FC00000 (NaN) -> 0x7FFFFFFF.
- Streaming: operands 3.0, -3.14, 2.5, 1.0e9 are applied on consecutive cycles. The expected results 3, -3, 3, 1000000000 appear on consecutive cycles, each 1 cycle after its input.
- Reset: drive rstn low mid-stream -> y = 0 immediately, without waiting for a clock edge. Release with x = 0x40400000 -> y = 3 after the next edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: float32 field layout and int32 saturation limits.
package fpu_pkg;

   localparam int unsigned FLOAT_BIAS = 127;
   localparam int unsigned EXP_W      = 8;
   localparam int unsigned MANT_W     = 23;
   localparam int unsigned SIG_W      = MANT_W + 1;
   localparam int unsigned INT_W      = 32;

   localparam logic [INT_W-1:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] mant;
   } float32_t;

endpackage

// File: rtl/ftoi_shift.sv
// Aligns the float significand to an integer magnitude; returns truncated value,
// first bit shifted out (round bit) and an overflow flag for |x| >= 2^31.
module ftoi_shift
   import fpu_pkg::*;
(
   input  logic [SIG_W-1:0] sig,
   input  logic [EXP_W-1:0] exp,
   output logic [INT_W-1:0] mag,
   output logic             rnd,
   output logic             ovf
);

   logic [SIG_W:0] ext;
   logic [4:0]     rs;
   logic [2:0]     ls;

   assign rs = 5'(8'd150 - exp);
   assign ls = 3'(exp - 8'd150);

   // exp 126 gives a right shift of 24, leaving only the round bit (0.5 <= |x| < 1)
   always_comb begin
      mag = '0;
      rnd = 1'b0;
      ovf = 1'b0;
      ext = '0;
      if (exp >= 8'd158) begin
         ovf = 1'b1;
      end else if (exp >= 8'd150) begin
         mag = INT_W'(sig) << ls;
      end else if (exp >= 8'd126) begin
         ext = {sig, 1'b0} >> rs;
         mag = INT_W'(ext[SIG_W:1]);
         rnd = ext[0];
      end
   end

endmodule

// File: rtl/ftoi.sv
// float32 -> int32 converter: round to nearest (ties away from zero), saturating,
// one registered stage, one conversion per cycle.
module ftoi
   import fpu_pkg::*;
(
   input  logic             clk,
   input  logic             rstn,
   input  logic [31:0]      x,
   output logic [31:0]      y
);

   float32_t         f;
   logic [INT_W-1:0] mag;
   logic             rnd;
   logic             ovf;
   logic [INT_W:0]   mag_r;
   logic [INT_W-1:0] y_nxt;

   assign f = x;

   ftoi_shift u_shift (
      .sig (SIG_W'({1'b1, f.mant})),
      .exp (f.exp),
      .mag (mag),
      .rnd (rnd),
      .ovf (ovf)
   );

   assign mag_r = {1'b0, mag} + (INT_W+1)'(rnd);

   // Special cases first, then sign-dependent saturation of the rounded magnitude
   always_comb begin
      y_nxt = '0;
      if (f.exp == 8'hFF && f.mant != '0) begin
         y_nxt = INT_MAX;
      end else if (ovf) begin
         y_nxt = f.sign ? INT_MIN : INT_MAX;
      end else if (f.exp == '0) begin
         y_nxt = '0;
      end else if (!f.sign) begin
         y_nxt = (mag_r > (INT_W+1)'(INT_MAX)) ? INT_MAX : mag_r[INT_W-1:0];
      end else begin
         y_nxt = (mag_r > (INT_W+1)'(INT_MIN)) ? INT_MIN : (~mag_r[INT_W-1:0] + 32'd1);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) y <= '0;
      else       y <= y_nxt;
   end

endmodule

// File: tb/tb_ftoi.sv
// Directed bench for ftoi: hand-computed vectors checked one cycle after drive.
module tb_ftoi;

   logic        clk;
   logic        rstn;
   logic [31:0] x;
   logic [31:0] y;

   int checks = 0;
   int errors = 0;

   ftoi dut (
      .clk  (clk),
      .rstn (rstn),
      .x    (x),
      .y    (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] exp_v);
      checks++;
      assert (y === exp_v) else begin
         errors++;
         $error("FAIL %s: y=%h expected %h", tag, y, exp_v);
      end
   endtask

   task automatic step(input string tag, input logic [31:0] xv, input logic [31:0] exp_v);
      @(negedge clk);
      x = xv;
      @(posedge clk);
      #1;
      check(tag, exp_v);
   endtask

   initial begin
      rstn = 1'b0;
      x    = 32'h0;
      #1;
      check("reset", 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      step("3.0",      32'h4040_0000, 32'h0000_0003);
      step("zero",     32'h0000_0000, 32'h0000_0000);
      step("neg_zero", 32'h8000_0000, 32'h0000_0000);

      step("-3.14",    32'hC048_F5C3, 32'hFFFF_FFFD);
      step("2.5",      32'h4020_0000, 32'h0000_0003);
      step("0.01",     32'h3C23_D70A, 32'h0000_0000);
      step("0.5",      32'h3F00_0000, 32'h0000_0001);
      step("-1.5",     32'hBFC0_0000, 32'hFFFF_FFFE);
      step("-0.5",     32'hBF00_0000, 32'hFFFF_FFFF);
      step("denorm",   32'h0040_0000, 32'h0000_0000);

      step("1e9",      32'h4E6E_6B28, 32'h3B9A_CA00);
      step("max157",   32'h4EFF_FFFF, 32'h7FFF_FF80);
      step("neg157",   32'hCEFF_FFFF, 32'h8000_0080);
      step("2^31",     32'h4F00_0000, 32'h7FFF_FFFF);
      step("-2^31",    32'hCF00_0000, 32'h8000_0000);
      step("+inf",     32'h7F80_0000, 32'h7FFF_FFFF);
      step("-inf",     32'hFF80_0000, 32'h8000_0000);
      step("nan",      32'h7FC0_0000, 32'h7FFF_FFFF);
      step("-nan",     32'hFFC0_0001, 32'h7FFF_FFFF);
      step("big",      32'h4B00_0001, 32'h0080_0001);

      // back-to-back stream: each step drives on consecutive cycles
      step("st_3.0",   32'h4040_0000, 32'h0000_0003);
      step("st_-3.14", 32'hC048_F5C3, 32'hFFFF_FFFD);
      step("st_2.5",   32'h4020_0000, 32'h0000_0003);
      step("st_1e9",   32'h4E6E_6B28, 32'h3B9A_CA00);

      // asynchronous reset mid-cycle, then release with 3.0 pending
      @(negedge clk);
      x = 32'h4F00_0000;
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      check("async_rst", 32'h0);
      @(negedge clk);
      check("rst_hold", 32'h0);
      x    = 32'h4040_0000;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("rst_release", 32'h0000_0003);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
